// File: rtl/rs232_pkg.sv
// Shared constants and FSM state type for the RS232 transmit path.
package rs232_pkg;

  // Bit period in clk_s cycles (50 MHz / 9600 bps) and the resulting frame length.
  localparam int clkNUM_bit      = 5208;
  localparam int FRAME_BITS      = 11;
  localparam int FRAME_CYCLES    = FRAME_BITS * clkNUM_bit;

  // Default done-wait limit; comfortably longer than one full frame.
  localparam int TIMEOUT_DEFAULT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } tx_arb_state_t;

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N.
module rr_pick
  import rs232_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_index
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  // Walk candidates ptr, ptr+1, ... and keep the first one requesting.
  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found           = 1'b1;
        o_onehot[w_idx]   = 1'b1;
        o_index           = w_idx;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one RS232 byte transmitter between NUM_REQ requesters,
// with bursts from the current owner until last/cap/abort/request drop.
//
// state | meaning
// IDLE  | no owner; pick a winner when the transmitter is free
// START | one-cycle start strobe to the transmitter
// WAIT  | wait for done strobe, abort on timeout
// ACK   | acknowledge owner; continue burst or release
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk_s,
  input  logic                 rst_s,
  input  logic [NUM_REQ-1:0]   iREQ,
  input  logic [NUM_REQ-1:0]   iLAST,
  input  logic [NUM_REQ*8-1:0] iDATA,
  output logic [NUM_REQ-1:0]   oACK,
  output logic [NUM_REQ-1:0]   oGRANT,
  output logic                 oTX_START,
  output logic [7:0]           oTX_DATA,
  input  logic                 iTX_BUSY,
  input  logic                 iTX_DONE,
  output logic                 oERR
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  tx_arb_state_t      r_state;
  tx_arb_state_t      w_next;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_owner;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_data;
  logic               r_last;
  logic [7:0]         r_burst;
  logic [TW-1:0]      r_to;
  logic               r_abort;
  logic               r_err;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [PW-1:0]      w_pick_idx;
  logic [PW-1:0]      w_sel_idx;
  logic [7:0]         w_sel_data;
  logic               w_sel_last;
  logic               w_grab;
  logic               w_release;
  logic               w_timeout;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .i_req    (iREQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_index  (w_pick_idx)
  );

  // In ACK the next byte comes from the owner; in IDLE from the new winner.
  assign w_sel_idx  = (r_state == ST_ACK) ? r_owner : w_pick_idx;
  assign w_sel_data = iDATA[{w_sel_idx, 3'b000} +: 8];
  assign w_sel_last = iLAST[w_sel_idx];
  assign w_grab     = ((r_state == ST_IDLE) && (w_next == ST_START)) ||
                      ((r_state == ST_ACK) && !w_release);

  assign oGRANT   = r_grant;
  assign oTX_DATA = r_data;
  assign oERR     = r_err;

  // State register.
  always_ff @(posedge clk_s) begin
    if (rst_s) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state, release/abort decisions and strobes.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_release = 1'b0;
    oTX_START = 1'b0;
    oACK      = '0;
    case (r_state)
      ST_IDLE: begin
        if (!iTX_BUSY && (|iREQ)) w_next = ST_START;
      end
      ST_START: begin
        oTX_START = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        // Done takes priority over an expiry in the same cycle.
        if (iTX_DONE) begin
          w_next = ST_ACK;
        end else if (r_to == TW'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = ST_ACK;
        end
      end
      ST_ACK: begin
        oACK      = r_grant;
        w_release = r_last || ((r_burst + 8'd1) == 8'(BURST_MAX)) ||
                    r_abort || !iREQ[r_owner];
        w_next    = w_release ? ST_IDLE : ST_START;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Grant, byte latch, burst/timeout counters, pointer and sticky error.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
      r_burst <= 8'd0;
      r_to    <= '0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_START) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_burst <= 8'd0;
          end
        end
        ST_START: begin
          r_to    <= '0;
          r_abort <= 1'b0;
        end
        ST_WAIT: begin
          // Counter stops at TIMEOUT because WAIT is left on that cycle.
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end else if (!iTX_DONE) begin
            r_to <= r_to + TW'(1);
          end
        end
        ST_ACK: begin
          r_burst <= r_burst + 8'd1;
          if (w_release) begin
            r_ptr   <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + PW'(1);
            r_grant <= '0;
          end
        end
        default: ;
      endcase
      if (w_grab) begin
        r_data <= w_sel_data;
        r_last <= w_sel_last;
      end
    end
  end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: queue-based requesters, a simple
// transmitter model, and per-scenario tasks with inline expectations.
module tb_rs232_tx_arbiter;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] data;
  } ev_t;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        sel;
  logic [3:0]  req, last;
  logic [31:0] data;
  logic        busy, model_done, man_done;
  logic        done;

  logic [3:0] m_ack, m_grant, c_ack, c_grant;
  logic       m_start, c_start, m_err, c_err;
  logic [7:0] m_data, c_data;
  logic [3:0] w_ack, w_grant;
  logic       w_start, w_err;
  logic [7:0] w_data;

  logic [8:0] rq [4][$];
  ev_t        start_log[$];
  ev_t        ack_log[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         auto_en;
  int         tx_delay;

  always #5 clk_s = ~clk_s;
  always @(posedge clk_s) cyc <= cyc + 1;

  assign done    = model_done | man_done;
  assign w_ack   = sel ? c_ack   : m_ack;
  assign w_grant = sel ? c_grant : m_grant;
  assign w_start = sel ? c_start : m_start;
  assign w_data  = sel ? c_data  : m_data;
  assign w_err   = sel ? c_err   : m_err;

  rs232_tx_arbiter dut (
    .clk_s(clk_s), .rst_s(rst_s), .iREQ(sel ? 4'b0000 : req), .iLAST(last),
    .iDATA(data), .oACK(m_ack), .oGRANT(m_grant), .oTX_START(m_start),
    .oTX_DATA(m_data), .iTX_BUSY(busy), .iTX_DONE(done), .oERR(m_err)
  );

  rs232_tx_arbiter #(.NUM_REQ(4), .BURST_MAX(3), .TIMEOUT(64)) dut_cap (
    .clk_s(clk_s), .rst_s(rst_s), .iREQ(sel ? req : 4'b0000), .iLAST(last),
    .iDATA(data), .oACK(c_ack), .oGRANT(c_grant), .oTX_START(c_start),
    .oTX_DATA(c_data), .iTX_BUSY(busy), .iTX_DONE(done), .oERR(c_err)
  );

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  // Requesters: present queue head, pop on acknowledge.
  initial begin
    req = '0; last = '0; data = '0;
    forever begin
      @(negedge clk_s);
      for (int k = 0; k < 4; k++)
        if (w_ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      for (int k = 0; k < 4; k++) begin
        if (rq[k].size() > 0) begin
          req[k] = 1'b1;
          last[k] = rq[k][0][8];
          data[8*k +: 8] = rq[k][0][7:0];
        end else begin
          req[k] = 1'b0;
          last[k] = 1'b0;
        end
      end
    end
  end

  // Transmitter: done strobe tx_delay cycles after the start strobe.
  initial begin
    int cnt;
    cnt = 0; busy = 1'b0; model_done = 1'b0;
    forever begin
      @(negedge clk_s);
      model_done = 1'b0;
      if (!auto_en) begin
        cnt = 0; busy = 1'b0;
      end else if (w_start) begin
        cnt = tx_delay; busy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin model_done = 1'b1; busy = 1'b0; end
      end
    end
  end

  // Event log of start strobes and acknowledges.
  initial begin
    forever begin
      @(negedge clk_s);
      if (w_start) start_log.push_back('{cyc, oh2idx(w_grant), w_data});
      if (w_ack != 4'b0000) ack_log.push_back('{cyc, oh2idx(w_ack), 8'h00});
    end
  end

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back({l, d});
  endtask

  task automatic clear_logs();
    start_log.delete();
    ack_log.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && ack_log.size() < n; i++) @(negedge clk_s);
    ok = (ack_log.size() >= n);
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && start_log.size() < n; i++) @(negedge clk_s);
    ok = (start_log.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_s);
      ok = (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) &&
           (rq[3].size() == 0) && (w_grant == 4'b0000) && !w_start;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_s);
    n_tests++; if (m_ack !== 4'b0000)  begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", m_ack); end
    n_tests++; if (m_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", m_grant); end
    n_tests++; if (m_start !== 1'b0)   begin n_fail++; $display("FAIL reset_start: got %b expected 0", m_start); end
    n_tests++; if (m_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data: got %h expected 00", m_data); end
    n_tests++; if (m_err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", m_err); end
    n_tests++; if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dut.r_ptr); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int ei;
    logic [7:0] ed;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 2; i++) push(k, 8'h40 + 8'(k*16 + i), 1'b1);
    wait_acks(8, 400, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rr_acks: got %0d expected 8", ack_log.size()); end
    for (int j = 0; j < 8; j++) begin
      ei = j % 4;
      ed = 8'h40 + 8'(ei*16 + j/4);
      n_tests++;
      if (j >= start_log.size()) begin
        n_fail++; $display("FAIL rr_order[%0d]: got none expected req %0d", j, ei);
      end else if (start_log[j].idx !== ei || start_log[j].data !== ed) begin
        n_fail++; $display("FAIL rr_order[%0d]: got req %0d data %h expected req %0d data %h",
                           j, start_log[j].idx, start_log[j].data, ei, ed);
      end
    end
  endtask

  task automatic test_burst();
    bit ok;
    int ei, gap;
    logic [7:0] ed;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    for (int i = 0; i < 4; i++) push(1, 8'h10 + 8'(i), (i == 3));
    repeat (3) @(posedge clk_s);
    #1 push(0, 8'h77, 1'b1);
    wait_acks(5, 300, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL burst_acks: got %0d expected 5", ack_log.size()); end
    for (int j = 0; j < 5 && j < start_log.size(); j++) begin
      ei = (j < 4) ? 1 : 0;
      ed = (j < 4) ? 8'h10 + 8'(j) : 8'h77;
      n_tests++;
      if (start_log[j].idx !== ei || start_log[j].data !== ed) begin
        n_fail++; $display("FAIL burst_order[%0d]: got req %0d data %h expected req %0d data %h",
                           j, start_log[j].idx, start_log[j].data, ei, ed);
      end
      if (j > 0) begin
        gap = (j < 4) ? 22 : 23;
        n_tests++;
        if (start_log[j].cyc - start_log[j-1].cyc !== gap) begin
          n_fail++; $display("FAIL burst_gap[%0d]: got %0d expected %0d",
                             j, start_log[j].cyc - start_log[j-1].cyc, gap);
        end
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    int c0;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    c0 = cyc;
    push(2, 8'hA5, 1'b1);
    wait_acks(1, 100, ok);
    n_tests++;
    if (!ok || start_log.size() < 1) begin
      n_fail++; $display("FAIL single_ack: got %0d acks expected 1", ack_log.size());
    end else begin
      n_tests++; if (start_log[0].idx !== 2 || start_log[0].data !== 8'hA5) begin
        n_fail++; $display("FAIL single_start: got req %0d data %h expected req 2 data a5",
                           start_log[0].idx, start_log[0].data); end
      n_tests++; if (start_log[0].cyc !== c0 + 1) begin
        n_fail++; $display("FAIL single_start_lat: got %0d expected %0d", start_log[0].cyc - c0, 1); end
      n_tests++; if (ack_log[0].idx !== 2) begin
        n_fail++; $display("FAIL single_ack_idx: got %0d expected 2", ack_log[0].idx); end
      n_tests++; if (ack_log[0].cyc !== start_log[0].cyc + 21) begin
        n_fail++; $display("FAIL single_ack_lat: got %0d expected 21", ack_log[0].cyc - start_log[0].cyc); end
      while (cyc < ack_log[0].cyc + 1) @(negedge clk_s);
      n_tests++; if (w_grant !== 4'b0000) begin
        n_fail++; $display("FAIL single_release: got %b expected 0000", w_grant); end
      n_tests++; if (dut.r_ptr !== 2'd3) begin
        n_fail++; $display("FAIL single_ptr: got %0d expected 3", dut.r_ptr); end
      repeat (5) @(negedge clk_s);
      n_tests++; if (start_log.size() !== 1) begin
        n_fail++; $display("FAIL single_count: got %0d expected 1", start_log.size()); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    auto_en = 1'b0;
    push(3, 8'h3C, 1'b1);
    wait_starts(1, 20, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL to_start: got %0d starts expected 1", start_log.size());
    end else begin
      s = start_log[0].cyc;
      while (cyc < s + 65536) @(negedge clk_s);
      n_tests++; if (w_ack !== 4'b0000 || w_err !== 1'b0) begin
        n_fail++; $display("FAIL to_early: got ack %b err %b expected 0000 0", w_ack, w_err); end
      @(negedge clk_s);
      n_tests++; if (w_ack !== 4'b1000) begin
        n_fail++; $display("FAIL to_ack: got %b expected 1000", w_ack); end
      n_tests++; if (w_err !== 1'b1) begin
        n_fail++; $display("FAIL to_err: got %b expected 1", w_err); end
      @(negedge clk_s);
      n_tests++; if (w_grant !== 4'b0000) begin
        n_fail++; $display("FAIL to_release: got %b expected 0000", w_grant); end
      repeat (5) @(negedge clk_s);
      n_tests++; if (w_err !== 1'b1) begin
        n_fail++; $display("FAIL to_sticky: got %b expected 1", w_err); end
    end
    auto_en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    auto_en = 1'b0;
    push(1, 8'h5A, 1'b1);
    wait_starts(1, 20, ok);
    repeat (5) @(negedge clk_s);
    @(posedge clk_s); #1;
    for (int k = 0; k < 4; k++) rq[k].delete();
    rst_s = 1'b1;
    @(posedge clk_s); #1;
    rst_s = 1'b0;
    @(negedge clk_s);
    n_tests++; if ({m_ack, m_grant, m_start, m_data, m_err} !== 18'd0) begin
      n_fail++; $display("FAIL rst_outputs: got ack %b grant %b start %b data %h err %b expected all 0",
                         m_ack, m_grant, m_start, m_data, m_err); end
    man_done = 1'b1;
    @(negedge clk_s);
    man_done = 1'b0;
    repeat (3) @(negedge clk_s);
    n_tests++; if (ack_log.size() !== 0 || m_grant !== 4'b0000) begin
      n_fail++; $display("FAIL rst_late_done: got %0d acks grant %b expected 0 acks grant 0000",
                         ack_log.size(), m_grant); end
    @(posedge clk_s); #1;
    clear_logs();
    auto_en = 1'b1;
    push(1, 8'h61, 1'b1);
    push(0, 8'h60, 1'b1);
    wait_acks(2, 200, ok);
    n_tests++;
    if (!ok || start_log.size() < 2) begin
      n_fail++; $display("FAIL rst_regrant: got %0d acks expected 2", ack_log.size());
    end else if (start_log[0].idx !== 0 || start_log[0].data !== 8'h60 || start_log[1].idx !== 1) begin
      n_fail++; $display("FAIL rst_regrant: got req %0d,%0d expected req 0,1",
                         start_log[0].idx, start_log[1].idx);
    end
  endtask

  task automatic test_burst_cap();
    bit ok;
    int ei;
    logic [7:0] ed;
    wait_idle(ok);
    @(posedge clk_s); #1;
    sel = 1'b1;
    tx_delay = 4;
    clear_logs();
    for (int i = 0; i < 5; i++) push(0, 8'h80 + 8'(i), 1'b0);
    push(1, 8'h91, 1'b1);
    wait_acks(6, 400, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cap_acks: got %0d expected 6", ack_log.size()); end
    for (int j = 0; j < 6 && j < start_log.size(); j++) begin
      ei = (j == 3) ? 1 : 0;
      ed = (j < 3) ? 8'h80 + 8'(j) : (j == 3) ? 8'h91 : 8'h80 + 8'(j - 1);
      n_tests++;
      if (start_log[j].idx !== ei || start_log[j].data !== ed) begin
        n_fail++; $display("FAIL cap_order[%0d]: got req %0d data %h expected req %0d data %h",
                           j, start_log[j].idx, start_log[j].data, ei, ed);
      end
    end
    wait_idle(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL cap_idle: got grant %b expected 0000", w_grant); end
  endtask

  task automatic test_done_at_expiry();
    bit ok;
    wait_idle(ok);
    @(posedge clk_s); #1;
    clear_logs();
    tx_delay = 65;
    push(1, 8'hE1, 1'b1);
    wait_acks(1, 200, ok);
    n_tests++;
    if (!ok || start_log.size() < 1) begin
      n_fail++; $display("FAIL tie_ack: got %0d acks expected 1", ack_log.size());
    end else begin
      n_tests++; if (ack_log[0].cyc !== start_log[0].cyc + 66 || ack_log[0].idx !== 1) begin
        n_fail++; $display("FAIL tie_ack_lat: got %0d req %0d expected 66 req 1",
                           ack_log[0].cyc - start_log[0].cyc, ack_log[0].idx); end
      n_tests++; if (c_err !== 1'b0) begin
        n_fail++; $display("FAIL tie_err: got %b expected 0", c_err); end
    end
    tx_delay = 20;
  endtask

  initial begin
    sel = 1'b0; rst_s = 1'b1; auto_en = 1'b1; tx_delay = 20; man_done = 1'b0;
    repeat (3) @(posedge clk_s);
    #1 rst_s = 1'b0;
    test_reset();
    test_round_robin();
    test_burst();
    test_single();
    test_timeout();
    test_reset_mid_wait();
    test_burst_cap();
    test_done_at_expiry();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin arbiter and sequencer that shares one RS232 byte transmitter between `NUM_REQ` requesters (command responder, status reporter, debug echo, ...). It grants the transmitter to one requester at a time and allows short bursts from the same requester. For each byte it issues a one-cycle start strobe, waits for the transmitter's done strobe and acknowledges the requester. It sits between the system logic and the UART TX datapath, alongside the RX path, in the same `clk_s` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `BURST_MAX`, default 16: maximum bytes per grant before forced release, 1..255.
- `TIMEOUT`, default 65535: cycles to wait for `iTX_DONE` before abort. Must exceed 11 × `clkNUM_bit` (57288 at 50 MHz / 9600 bps).

- `clk_s` input 1: system clock; the only clock.
- `rst_s` input 1: synchronous, active-high reset.
- `iREQ` input NUM_REQ: per-requester byte-valid, held until acknowledged.
- `iLAST` input NUM_REQ: per-requester last-byte-of-burst flag, qualified with `iREQ`.
- `iDATA` input NUM_REQ*8: packed bytes; requester k occupies [8k+7:8k].
- `oACK` output NUM_REQ: one-cycle pulse when the requester's byte is fully sent or aborted.
- `oGRANT` output NUM_REQ: one-hot current owner; all zero when idle.
- `oTX_START` output 1: one-cycle start strobe to the transmitter.
- `oTX_DATA` output 8: byte to transmit, stable from `oTX_START` until `iTX_DONE`.
- `iTX_BUSY` input 1: transmitter busy.
- `iTX_DONE` input 1: one-cycle pulse at the end of the stop bit.
- `oERR` output 1: sticky timeout flag, cleared only by reset.

## Operation
- FSM states: IDLE, START, WAIT, ACK.
- **IDLE**
  - When `iTX_BUSY`=0 and any `iREQ` is high, choose the winner by rotating priority, starting at `ptr` and searching upward modulo `NUM_REQ`.
  - Set `oGRANT`, latch `iDATA[winner]` into `oTX_DATA` and latch `iLAST[winner]`.
  - Clear the burst counter, then go to START.
- **START**: `oTX_START`=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- **WAIT**
  - Count cycles.
  - On `iTX_DONE`, go to ACK.
  - If the count reaches `TIMEOUT` without `iTX_DONE`, set `oERR` and go to ACK (the abort path).
  - If `iTX_DONE` and the timeout expiry coincide, `iTX_DONE` wins; `oERR` stays unchanged.
- **ACK**
  - Pulse `oACK[owner]` and increment the burst counter.
  - Release if any of these holds: latched last flag = 1, burst count = `BURST_MAX`, abort occurred, or `iREQ[owner]`=0 in this cycle.
  - On release: `ptr` ← owner+1 mod `NUM_REQ`, `oGRANT` ← 0, go to IDLE.
  - Otherwise: latch the owner's next `iDATA`/`iLAST` and go directly to START; other requesters stay blocked.
- **Ignored inputs**
  - `iTX_DONE` outside WAIT.
  - `iREQ` changes of non-owners.
- **Width rules**
  - Burst counter is 8 bits.
  - Timeout counter is `$clog2(TIMEOUT+1)` bits and saturates at `TIMEOUT`.
  - `ptr` is `$clog2(NUM_REQ)` bits and wraps from `NUM_REQ`-1 to 0.

## Timing
- Reset values: `oACK`=0, `oGRANT`=0, `oTX_START`=0, `oTX_DATA`=8'h00, `oERR`=0, `ptr`=0, state IDLE.
- Reset in any state aborts the transfer silently: no `oACK` is issued.
- `iREQ` seen in IDLE at cycle N: `oGRANT` and `oTX_START` are high at N+1; WAIT begins at N+2.
- `iTX_DONE` at cycle M: `oACK` is high at M+1.
- Within a burst, the next `oTX_START` is at M+2.
- After release, IDLE is entered at M+2 and the next grant's `oTX_START` is at M+3 at the earliest.
- `oTX_DATA` changes only on entry to START.
- The requester must hold `iDATA` stable while `iREQ`=1 and must present its next byte in the cycle after `oACK`, or drop `iREQ`.

## Structure
- Shared package `rs232_pkg`:
  - `clkNUM_bit` (5208) and the derived frame length.
  - FSM state enum `tx_arb_state_t`.
  - Default `TIMEOUT` constant.
- One sub-module: `rr_pick`, a combinational rotating-priority one-hot picker with inputs (req, ptr) and outputs (onehot, index).
- The FSM, counters and latches stay in the top module.

## Test plan
- **Single byte**: `iREQ[2]`=1, `iDATA`=8'hA5, `iLAST[2]`=1, `iTX_DONE` 20 cycles after START → one `oTX_START`, `oTX_DATA`=A5, `oACK[2]` one cycle later, `ptr`=3, `oGRANT`=0.
- **Round robin**: all four request continuously with `iLAST`=1 → grant order 0, 1, 2, 3, 0; each gets exactly one byte per turn.
- **Burst**: requester 1 sends 8'h10..8'h13 with `iLAST` on 8'h13 while requester 0 waits → four back-to-back STARTs for requester 1, then requester 0 is granted.
- **Burst cap**: `BURST_MAX`=3, requester 0 streams bytes with `iLAST`=0 → released after 3 `oACK`s; requester 1 is served next.
- **Timeout**: `iTX_DONE` never arrives → `oACK` at `TIMEOUT`+1 cycles after WAIT entry, `oERR`=1 and sticky, arbiter returns to IDLE.
- **Reset mid-WAIT**: assert `rst_s` for one cycle → all outputs 0 next cycle; a late `iTX_DONE` is ignored; the next grant goes to requester 0.
